// File: rtl/bf16_operand_sequencer_pkg.sv
// Shared definitions for the bf16 operand sequencer: FSM encodings, display codes, bfloat16 literals.
// Pure constants and a sizing helper; no logic, no latency, no backpressure.
package bf16_operand_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_LOAD_A = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_LOAD_C = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_SHOW   = 3'd5,
      ST_ERROR  = 3'd6
   } seq_state_t;

   localparam logic [15:0] ERR_CODE   = 16'hDEAD;
   localparam logic [15:0] BF16_ZERO  = 16'h0000;
   localparam logic [15:0] BF16_ONE   = 16'h3F80;
   localparam logic [15:0] BF16_TWO   = 16'h4000;
   localparam logic [15:0] BF16_THREE = 16'h4040;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bf16_operand_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse on the debounced rising edge.
// Latency: DEBOUNCE_CYCLES+2 cycles from a stable input change to press; no backpressure (pulse is fire-and-forget).
module btn_debounce
   import bf16_operand_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [1:0]    sync_vld;
   logic          btn_level;
   logic          armed;
   logic [CW-1:0] stab_cnt;
   logic          stable_done;

   assign stable_done = (sync_q[1] != btn_level) && (stab_cnt == CNT_LAST);

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         sync_vld  <= '0;
         btn_level <= 1'b0;
         armed     <= 1'b0;
         stab_cnt  <= '0;
         press     <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_raw};
         sync_vld <= {sync_vld[0], 1'b1};
         press    <= 1'b0;
         // A real low sample must be seen first, so a button held through reset never fires.
         if (sync_vld[1] && !sync_q[1]) begin
            armed <= 1'b1;
         end
         if (sync_q[1] == btn_level) begin
            stab_cnt <= '0;
         end else if (stable_done) begin
            stab_cnt  <= '0;
            btn_level <= sync_q[1];
            press     <= sync_q[1] & armed;
         end else begin
            stab_cnt <= stab_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bf16_operand_sequencer.sv
// Sequences three switch-entered bf16 operands into an FMA, then displays the result or a timeout code.
// Latency: outputs register one cycle after press/fma_done; no backpressure, presses outside LOAD/SHOW/ERROR are dropped.
module bf16_operand_sequencer
   import bf16_operand_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic [15:0] sw,
   input  logic        btn_next,
   input  logic [15:0] fma_result,
   input  logic        fma_done,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic [15:0] op_c,
   output logic        fma_start,
   output logic        dm_write,
   output logic [15:0] data_in,
   output logic [2:0]  state_led
);

   localparam int unsigned   TW       = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   seq_state_t    state, state_n;
   logic [15:0]   op_a_n, op_b_n, op_c_n, data_in_n;
   logic          dm_write_n, fma_start_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic          press;
   logic          press_ok;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .btn_raw   (btn_next),
      .press     (press)
   );

   // A press landing right on a display strobe is dropped so dm_write never repeats back-to-back.
   assign press_ok  = press & ~dm_write;
   assign state_led = state;

   always_comb begin
      state_n     = state;
      op_a_n      = op_a;
      op_b_n      = op_b;
      op_c_n      = op_c;
      data_in_n   = data_in;
      dm_write_n  = 1'b0;
      fma_start_n = 1'b0;
      tmo_cnt_n   = tmo_cnt;
      case (state)
         ST_LOAD_A: begin
            if (press_ok) begin
               op_a_n     = sw;
               data_in_n  = sw;
               dm_write_n = 1'b1;
               state_n    = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            if (press_ok) begin
               op_b_n     = sw;
               data_in_n  = sw;
               dm_write_n = 1'b1;
               state_n    = ST_LOAD_C;
            end
         end
         ST_LOAD_C: begin
            if (press_ok) begin
               op_c_n     = sw;
               data_in_n  = sw;
               dm_write_n = 1'b1;
               state_n    = ST_START;
            end
         end
         ST_START: begin
            fma_start_n = 1'b1;
            tmo_cnt_n   = '0;
            state_n     = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the final counted cycle still beats the timeout.
            if (fma_done) begin
               data_in_n  = fma_result;
               dm_write_n = 1'b1;
               state_n    = ST_SHOW;
            end else if (tmo_cnt == TMO_LAST) begin
               data_in_n  = ERR_CODE;
               dm_write_n = 1'b1;
               state_n    = ST_ERROR;
            end else begin
               tmo_cnt_n = tmo_cnt + TW'(1);
            end
         end
         ST_SHOW, ST_ERROR: begin
            if (press_ok) begin
               data_in_n  = BF16_ZERO;
               dm_write_n = 1'b1;
               state_n    = ST_LOAD_A;
            end
         end
         default: begin
            state_n = ST_LOAD_A;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state     <= ST_LOAD_A;
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         data_in   <= '0;
         dm_write  <= 1'b0;
         fma_start <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state     <= state_n;
         op_a      <= op_a_n;
         op_b      <= op_b_n;
         op_c      <= op_c_n;
         data_in   <= data_in_n;
         dm_write  <= dm_write_n;
         fma_start <= fma_start_n;
         tmo_cnt   <= tmo_cnt_n;
      end
   end

endmodule

// File: tb/tb_bf16_operand_sequencer.sv
// Directed bench for bf16_operand_sequencer with short debounce/timeout parameters.
`timescale 1ns/1ps
module tb_bf16_operand_sequencer;
   import bf16_operand_sequencer_pkg::*;

   logic        clk_100MHz = 1'b0;
   logic        reset      = 1'b1;
   logic [15:0] sw         = '0;
   logic        btn_next   = 1'b0;
   logic [15:0] fma_result = '0;
   logic        fma_done   = 1'b0;
   logic [15:0] op_a, op_b, op_c, data_in;
   logic        fma_start, dm_write;
   logic [2:0]  state_led;

   bf16_operand_sequencer #(
      .DEBOUNCE_CYCLES(8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .sw        (sw),
      .btn_next  (btn_next),
      .fma_result(fma_result),
      .fma_done  (fma_done),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_c      (op_c),
      .fma_start (fma_start),
      .dm_write  (dm_write),
      .data_in   (data_in),
      .state_led (state_led)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   logic [15:0] dm_dat_q[$];
   int          dm_cyc_q[$];
   int          fs_cnt    = 0;
   int          fs_cyc    = 0;
   int          rule_viol = 0;
   logic        prev_dm   = 1'b0;

   always @(negedge clk_100MHz) begin
      if (reset) begin
         prev_dm = 1'b0;
      end else begin
         if (dm_write) begin
            dm_dat_q.push_back(data_in);
            dm_cyc_q.push_back(cyc);
         end
         if (fma_start) begin
            fs_cnt++;
            fs_cyc = cyc;
         end
         if (dm_write && (prev_dm || fma_start)) rule_viol++;
         prev_dm = dm_write;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_100MHz);
         #1;
      end
   endtask

   task automatic press_hold(input logic [15:0] val);
      sw       = val;
      btn_next = 1'b1;
      for (int i = 0; i < 20 && dm_dat_q.size() == 0; i++) tick(1);
   endtask

   task automatic release_btn();
      btn_next = 1'b0;
      tick(14);
   endtask

   task automatic wait_dm(input string tag, input int budget, output logic [15:0] d, output int c);
      for (int i = 0; i < budget && dm_dat_q.size() == 0; i++) tick(1);
      check({tag, "_seen"}, (dm_dat_q.size() != 0), 1);
      if (dm_dat_q.size() != 0) begin
         d = dm_dat_q.pop_front();
         c = dm_cyc_q.pop_front();
      end else begin
         d = 16'hxxxx;
         c = -1000;
      end
   endtask

   task automatic wait_fs(input string tag, input int budget);
      for (int i = 0; i < budget && !fma_start; i++) tick(1);
      check(tag, fma_start, 1);
   endtask

   int last_dm_cyc = 0;

   task automatic load_one(input string tag, input logic [15:0] val, input logic [2:0] st_exp, input bit last);
      logic [15:0] d;
      int          c;
      press_hold(val);
      wait_dm(tag, 2, d, c);
      check({tag, "_echo"}, d, val);
      check({tag, "_state"}, state_led, st_exp);
      last_dm_cyc = c;
      if (last) btn_next = 1'b0;
      else release_btn();
   endtask

   task automatic clear_press(input string tag);
      logic [15:0] d;
      int          c;
      press_hold(16'h5555);
      wait_dm(tag, 2, d, c);
      check({tag, "_dat"}, d, 16'h0000);
      check({tag, "_state"}, state_led, 3'd0);
      release_btn();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      int          c;
      int          fs0;

      // reset state
      reset = 1'b1;
      tick(3);
      check("rst_op_a", op_a, 0);
      check("rst_op_b", op_b, 0);
      check("rst_op_c", op_c, 0);
      check("rst_data_in", data_in, 0);
      check("rst_dm_write", dm_write, 0);
      check("rst_fma_start", fma_start, 0);
      check("rst_state", state_led, 0);
      reset = 1'b0;
      tick(3);

      // fma_done outside WAIT is ignored
      fma_result = 16'h1234;
      fma_done   = 1'b1;
      tick(1);
      fma_done = 1'b0;
      tick(3);
      check("idle_done_no_dm", dm_dat_q.size(), 0);
      check("idle_done_state", state_led, 0);

      // three captures, then FMA answers 5 cycles after start
      load_one("cap_a", 16'h3F80, 3'd1, 1'b0);
      load_one("cap_b", 16'h4000, 3'd2, 1'b0);
      load_one("cap_c", 16'h3F80, 3'd3, 1'b1);
      wait_fs("fs1_seen", 5);
      check("fs1_delay", fs_cyc - last_dm_cyc, 1);
      check("fs1_state", state_led, 3'd4);
      check("op_a", op_a, 16'h3F80);
      check("op_b", op_b, 16'h4000);
      check("op_c", op_c, 16'h3F80);
      tick(4);
      fma_result = 16'h4040;
      fma_done   = 1'b1;
      tick(1);
      fma_done = 1'b0;
      wait_dm("res1", 3, d, c);
      check("res1_dat", d, 16'h4040);
      check("res1_state", state_led, 3'd5);
      check("res1_delay", c - fs_cyc, 5);
      check("fs1_count", fs_cnt, 1);
      tick(12);
      clear_press("clr1");
      check("clr1_op_a_kept", op_a, 16'h3F80);
      check("clr1_op_c_kept", op_c, 16'h3F80);

      // no done at all: timeout after 16 WAIT cycles
      load_one("t_a", 16'h4040, 3'd1, 1'b0);
      load_one("t_b", 16'h4000, 3'd2, 1'b0);
      load_one("t_c", 16'h3F80, 3'd3, 1'b1);
      wait_fs("fs2_seen", 5);
      wait_dm("tmo", 25, d, c);
      check("tmo_dat", d, 16'hDEAD);
      check("tmo_state", state_led, 3'd6);
      check("tmo_delay", c - fs_cyc, 16);
      tick(4);
      clear_press("clr2");

      // done on the last counted WAIT cycle wins over timeout
      load_one("d_a", 16'h4000, 3'd1, 1'b0);
      load_one("d_b", 16'h4040, 3'd2, 1'b0);
      load_one("d_c", 16'h4000, 3'd3, 1'b1);
      wait_fs("fs3_seen", 5);
      tick(15);
      fma_result = 16'h3F80;
      fma_done   = 1'b1;
      tick(1);
      fma_done = 1'b0;
      wait_dm("edge", 3, d, c);
      check("edge_dat", d, 16'h3F80);
      check("edge_state", state_led, 3'd5);
      check("edge_delay", c - fs_cyc, 16);
      tick(4);
      check("edge_no_extra_dm", dm_dat_q.size(), 0);
      check("edge_state_hold", state_led, 3'd5);
      clear_press("clr3");

      // bouncing button: short runs rejected, one capture after the stable run
      sw = 16'h4040;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) btn_next = ~btn_next;
         tick(1);
      end
      btn_next = 1'b1;
      tick(20);
      release_btn();
      check("bounce_count", dm_dat_q.size(), 1);
      wait_dm("bounce", 1, d, c);
      check("bounce_dat", d, 16'h4040);
      check("bounce_op_a", op_a, 16'h4040);
      check("bounce_state", state_led, 3'd1);

      // reset in WAIT with the button held across release
      load_one("r_b", 16'h3F80, 3'd2, 1'b0);
      load_one("r_c", 16'h4000, 3'd3, 1'b1);
      wait_fs("fs4_seen", 5);
      tick(3);
      #2;
      reset    = 1'b1;
      btn_next = 1'b1;
      #1;
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_op_b", op_b, 0);
      check("mid_rst_op_c", op_c, 0);
      check("mid_rst_data_in", data_in, 0);
      check("mid_rst_dm_write", dm_write, 0);
      check("mid_rst_fma_start", fma_start, 0);
      check("mid_rst_state", state_led, 0);
      tick(2);
      dm_dat_q.delete();
      dm_cyc_q.delete();
      fs0   = fs_cnt;
      reset = 1'b0;
      tick(30);
      check("held_no_dm", dm_dat_q.size(), 0);
      check("held_no_fs", fs_cnt, fs0);
      check("held_state", state_led, 0);
      check("held_op_a", op_a, 0);
      release_btn();
      load_one("post_rst", 16'h3F80, 3'd1, 1'b0);
      check("post_rst_op_a", op_a, 16'h3F80);

      check("no_dm_rule_viol", rule_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
